// File: rtl/uart_pkg.sv
// Shared UART definitions: per-rate bit-time table, receiver state encoding
// and the bit-time counter width, used by both the TX and RX engines.
package uart_pkg;

    localparam int unsigned CNT_W      = 19;
    localparam int unsigned REF_CLK_HZ = 100000000;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;

    // Clocks per bit at REF_CLK_HZ; indices 12..15 alias the fastest rate.
    function automatic logic [CNT_W-1:0] base_bit_time(input logic [3:0] idx);
        logic [CNT_W-1:0] v;
        case (idx)
            4'd0:    v = 19'd333333;
            4'd1:    v = 19'd83333;
            4'd2:    v = 19'd41667;
            4'd3:    v = 19'd20833;
            4'd4:    v = 19'd10417;
            4'd5:    v = 19'd5208;
            4'd6:    v = 19'd2604;
            4'd7:    v = 19'd1736;
            4'd8:    v = 19'd868;
            4'd9:    v = 19'd434;
            4'd10:   v = 19'd217;
            default: v = 19'd109;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/uart_rx_bitclk.sv
// Loadable bit-time down-counter for the UART receiver; emits a one-cycle
// sample tick each time the count reaches zero, then reloads a full bit-time.
module uart_rx_bitclk
    import uart_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             i_en,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic [CNT_W-1:0] i_reload_val,
    output logic             o_tick
);

    logic [CNT_W-1:0] r_cnt;

    // Down-counter: load wins, idles at zero while disabled, reloads on expiry.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (!i_en) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (r_cnt == {CNT_W{1'b0}}) begin
            r_cnt <= i_reload_val;
        end else begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_tick = i_en && (r_cnt == {CNT_W{1'b0}});

endmodule

// File: rtl/uart_rx_engine.sv
// UART receiver: 2-FF synchronised line, frame FSM, host read/overrun flags.
// Optional UART_RX_MAJORITY_VOTE_EN: 3-sample majority vote around mid-bit.
module uart_rx_engine
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ = 100000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       bit8,
    input  logic       parity_en,
    input  logic       odd_n_even,
    input  logic [3:0] baud_val,
    input  logic       rd,
    output logic [7:0] data,
    output logic       rxrdy,
    output logic       perr,
    output logic       ferr,
    output logic       ovf
);

    function automatic logic [CNT_W-1:0] scaled_bit_time(input logic [3:0] idx);
        logic [63:0] v;
        v = (64'(base_bit_time(idx)) * 64'(CLK_HZ)) / 64'(REF_CLK_HZ);
        return v[CNT_W-1:0];
    endfunction

    logic [CNT_W-1:0] w_tbl [16];
    for (genvar g = 0; g < 16; g++) begin : g_tbl
        assign w_tbl[g] = scaled_bit_time(4'(g));
    end

    rx_state_t        r_state;
    logic             r_sync1, r_sync2, r_prev;
    logic             r_bit8, r_par_en, r_odd;
    logic [3:0]       r_baud;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             r_perr_pend;
    logic [7:0]       r_data;
    logic             r_rxrdy, r_perr, r_ferr, r_ovf;

    logic             w_fall, w_start, w_tick, w_act, w_bit, w_done;
    logic [CNT_W-1:0] w_half_load, w_reload;

    // Two-flop synchroniser plus one delayed copy for falling-edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign w_fall      = r_prev & ~r_sync2;
    assign w_start     = (r_state == ST_IDLE) && w_fall;
    assign w_half_load = (w_tbl[baud_val] >> 1) - CNT_W'(1);
    assign w_reload    = w_tbl[r_baud] - CNT_W'(1);

    uart_rx_bitclk u_bitclk (
        .clk          (clk),
        .reset        (reset),
        .i_en         (r_state != ST_IDLE),
        .i_load       (w_start),
        .i_load_val   (w_half_load),
        .i_reload_val (w_reload),
        .o_tick       (w_tick)
    );

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic r_prev2, r_tick_d;

    // Decide one clock after mid-bit so the +1 sample is available.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev2  <= 1'b1;
            r_tick_d <= 1'b0;
        end else begin
            r_prev2  <= r_prev;
            r_tick_d <= w_tick;
        end
    end

    assign w_act = r_tick_d;
    assign w_bit = (r_prev2 & r_prev) | (r_prev2 & r_sync2) | (r_prev & r_sync2);
`else
    assign w_act = w_tick;
    assign w_bit = r_sync2;
`endif

    assign w_done = (r_state == ST_STOP) && w_act;

    // Frame FSM plus the registered host-facing byte and flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_bit8      <= 1'b0;
            r_par_en    <= 1'b0;
            r_odd       <= 1'b0;
            r_baud      <= 4'd0;
            r_bit_idx   <= 3'd0;
            r_shift     <= 8'h00;
            r_perr_pend <= 1'b0;
            r_data      <= 8'h00;
            r_rxrdy     <= 1'b0;
            r_perr      <= 1'b0;
            r_ferr      <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_fall) begin
                        r_bit8      <= bit8;
                        r_par_en    <= parity_en;
                        r_odd       <= odd_n_even;
                        r_baud      <= baud_val;
                        r_bit_idx   <= 3'd0;
                        r_shift     <= 8'h00;
                        r_perr_pend <= 1'b0;
                        r_state     <= ST_START;
                    end
                end
                ST_START: begin
                    if (w_act) begin
                        r_state <= w_bit ? ST_IDLE : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_act) begin
                        r_shift[r_bit_idx] <= w_bit;
                        if (r_bit_idx == (r_bit8 ? 3'd7 : 3'd6)) begin
                            r_state <= r_par_en ? ST_PARITY : ST_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (w_act) begin
                        // Unused bit 7 is zero in 7-bit mode, so a full XOR is safe.
                        r_perr_pend <= (^r_shift) ^ w_bit ^ r_odd;
                        r_state     <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (w_act) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            if (w_done) begin
                if (!r_rxrdy || rd) begin
                    r_data  <= r_shift;
                    r_perr  <= r_perr_pend;
                    r_ferr  <= ~w_bit;
                    r_rxrdy <= 1'b1;
                    r_ovf   <= 1'b0;
                end else begin
                    r_ovf <= 1'b1;
                end
            end else if (rd && r_rxrdy) begin
                r_rxrdy <= 1'b0;
                r_perr  <= 1'b0;
                r_ferr  <= 1'b0;
                r_ovf   <= 1'b0;
            end
        end
    end

    assign data  = r_data;
    assign rxrdy = r_rxrdy;
    assign perr  = r_perr;
    assign ferr  = r_ferr;
    assign ovf   = r_ovf;

endmodule

// File: tb/tb_uart_rx_engine.sv
// Self-checking bench for uart_rx_engine: directed vector table, hand-written
// overrun/false-start/reset sequences and random frames against a byte-level model.
module tb_uart_rx_engine;

    typedef struct {
        logic [7:0] din;
        logic       b8, pen, odd, pbit, stop;
        logic [3:0] baud;
        logic [7:0] exp_data;
        logic       exp_perr, exp_ferr;
    } vec_t;

    int bt_tab [16] = '{333333, 83333, 41667, 20833, 10417, 5208, 2604, 1736,
                        868, 434, 217, 109, 109, 109, 109, 109};

    logic       clk = 1'b0;
    logic       reset, rx, bit8, parity_en, odd_n_even, rd;
    logic [3:0] baud_val;
    logic [7:0] data;
    logic       rxrdy, perr, ferr, ovf;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   rise_cyc = -1;
    logic prev_rdy = 1'b0;

    uart_rx_engine #(.CLK_HZ(100000000)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .bit8       (bit8),
        .parity_en  (parity_en),
        .odd_n_even (odd_n_even),
        .baud_val   (baud_val),
        .rd         (rd),
        .data       (data),
        .rxrdy      (rxrdy),
        .perr       (perr),
        .ferr       (ferr),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rxrdy === 1'b1 && prev_rdy !== 1'b1) rise_cyc = cyc;
        prev_rdy = rxrdy;
    end

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b, input int n);
        rx = b;
        wait_cyc(n);
    endtask

    task automatic pulse_rd;
        rd = 1'b1;
        wait_cyc(1);
        rd = 1'b0;
    endtask

    task automatic send_frame(input vec_t v, output int s);
        int t;
        t = bt_tab[v.baud];
        bit8 = v.b8; parity_en = v.pen; odd_n_even = v.odd; baud_val = v.baud;
        s = cyc;
        drive_bit(1'b0, t);
        for (int i = 0; i < (v.b8 ? 8 : 7); i++) drive_bit(v.din[i], t);
        if (v.pen) drive_bit(v.pbit, t);
        drive_bit(v.stop, t);
        rx = 1'b1;
    endtask

    // Send one frame expecting rxrdy low beforehand, check the result, then read it.
    task automatic run_frame(input string tag, input vec_t v);
        int s, t, n, mid;
        send_frame(v, s);
        wait_cyc(5);
        t   = bt_tab[v.baud];
        n   = (v.b8 ? 8 : 7) + (v.pen ? 1 : 0);
        mid = s + t * (n + 1) + t / 2;
        check({tag, " data"},  32'(data),  32'(v.exp_data));
        check({tag, " perr"},  32'(perr),  32'(v.exp_perr));
        check({tag, " ferr"},  32'(ferr),  32'(v.exp_ferr));
        check({tag, " rxrdy"}, 32'(rxrdy), 32'd1);
        check({tag, " ovf"},   32'(ovf),   32'd0);
        checks++;
        if (rise_cyc <= mid || rise_cyc > mid + 6) begin
            failures++;
            $display("FAIL %s latency actual_rise=%0d required_window=%0d..%0d",
                     tag, rise_cyc, mid + 1, mid + 6);
        end
        pulse_rd;
        check({tag, " rd rxrdy"}, 32'(rxrdy), 32'd0);
        check({tag, " rd flags"}, 32'({perr, ferr, ovf}), 32'd0);
        pulse_rd;
        check({tag, " idle rd data"}, 32'(data), 32'(v.exp_data));
    endtask

    vec_t vecs [9];
    vec_t v;
    int   s, s0, target, ones;

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd11, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd11, 8'hA5, 1'b1, 1'b0};
        vecs[2] = '{8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd11, 8'h55, 1'b0, 1'b1};
        vecs[3] = '{8'h2A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd11, 8'h2A, 1'b0, 1'b0};
        vecs[4] = '{8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd13, 8'h7F, 1'b0, 1'b0};
        vecs[5] = '{8'h3C, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd15, 8'h3C, 1'b0, 1'b0};
        vecs[6] = '{8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd11, 8'h01, 1'b1, 1'b0};
        vecs[7] = '{8'h80, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd12, 8'h00, 1'b1, 1'b0};
        vecs[8] = '{8'hC3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd11, 8'hC3, 1'b0, 1'b0};

        reset = 1'b1; rx = 1'b1; rd = 1'b0;
        bit8 = 1'b1; parity_en = 1'b0; odd_n_even = 1'b0; baud_val = 4'd11;
        wait_cyc(3);
        check("reset data", 32'(data), 32'h0);
        check("reset flags", 32'({rxrdy, perr, ferr, ovf}), 32'h0);
        reset = 1'b0;
        wait_cyc(5);

        for (int i = 0; i < 9; i++) run_frame($sformatf("vec%0d", i), vecs[i]);

        // Overrun: two unread frames keep the first byte and flag ovf.
        v = '{8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd11, 8'h11, 1'b0, 1'b0};
        send_frame(v, s); wait_cyc(5);
        v.din = 8'h22;
        send_frame(v, s); wait_cyc(5);
        check("ovf data", 32'(data), 32'h11);
        check("ovf flag", 32'(ovf), 32'd1);
        check("ovf rxrdy", 32'(rxrdy), 32'd1);

        // rd landing on the completion cycle of the third frame.
        v.din  = 8'h33;
        s0     = cyc;
        target = s0 + 3 + (109 >> 1) + 109 * 9 - 1;
        fork
            send_frame(v, s);
            begin
                repeat (target - s0) @(posedge clk);
                #1 rd = 1'b1;
                @(posedge clk);
                #1 rd = 1'b0;
            end
        join
        wait_cyc(5);
        check("rd@done data", 32'(data), 32'h33);
        check("rd@done rxrdy", 32'(rxrdy), 32'd1);
        check("rd@done ovf", 32'(ovf), 32'd0);
        pulse_rd;

        // False start: short low pulse must not produce a frame or flags.
        drive_bit(1'b0, 30);
        rx = 1'b1;
        wait_cyc(150);
        check("false start flags", 32'({rxrdy, perr, ferr, ovf}), 32'h0);
        run_frame("after false start", '{8'h96, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd11, 8'h96, 1'b0, 1'b0});

        // Leave a byte with perr pending, then reset at data bit 3 of the next frame.
        v = '{8'hC3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd11, 8'hC3, 1'b1, 1'b0};
        send_frame(v, s); wait_cyc(5);
        check("pre-reset perr", 32'(perr), 32'd1);
        drive_bit(1'b0, 109);
        drive_bit(1'b0, 109);
        drive_bit(1'b1, 109);
        drive_bit(1'b0, 109);
        reset = 1'b1; rx = 1'b1;
        wait_cyc(2);
        reset = 1'b0;
        wait_cyc(1);
        check("midreset data", 32'(data), 32'h0);
        check("midreset flags", 32'({rxrdy, perr, ferr, ovf}), 32'h0);
        wait_cyc(300);
        run_frame("post reset", '{8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd11, 8'h5A, 1'b0, 1'b0});

        // Random frames against the byte-level model.
        for (int k = 0; k < 12; k++) begin
            v.din  = 8'($urandom);
            v.b8   = 1'($urandom);
            v.pen  = 1'($urandom);
            v.odd  = 1'($urandom);
            v.pbit = 1'($urandom);
            v.stop = ($urandom_range(0, 3) != 0);
            v.baud = 4'(11 + $urandom_range(0, 4));
            v.exp_data = v.b8 ? v.din : {1'b0, v.din[6:0]};
            ones       = $countones(v.exp_data) + (v.pbit ? 1 : 0);
            v.exp_perr = v.pen && ((ones % 2) != (v.odd ? 1 : 0));
            v.exp_ferr = !v.stop;
            run_frame($sformatf("rnd%0d", k), v);
            wait_cyc(int'($urandom_range(3, 40)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_engine.md
UART_RX_ENGINE -- requirements
Module: uart_rx_engine

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100000000, system clock frequency used to select the bit-time table.
REQ-002 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-005 SHALL have port bit8  input  1  1 = 8 data bits, 0 = 7 data bits.
REQ-006 SHALL have port parity_en  input  1  1 = parity bit present after data.
REQ-007 SHALL have port odd_n_even  input  1  1 = odd parity, 0 = even parity.
REQ-008 SHALL have port baud_val  input  4  index into the shared bit-time table.
REQ-009 SHALL have port rd  input  1  one-cycle read strobe from host; acknowledges the held byte.
REQ-010 SHALL have port data  output  8  received byte; bit 7 forced 0 in 7-bit mode.
REQ-011 SHALL have ports rxrdy, perr, ferr, ovf  output  1 each  byte valid, parity error, framing error, overrun.

Function
REQ-012 SHALL pass rx through a 2-FF synchronizer; all decisions use the synchronized value.
REQ-013 SHALL implement states IDLE, START, DATA, PARITY, STOP.
REQ-014 IDLE -> START on synchronized falling edge; bit8, parity_en, odd_n_even, baud_val SHALL be latched at that cycle and held for the whole frame.
REQ-015 START SHALL wait half a bit-time (table value >> 1); line low -> DATA, line high -> IDLE (false start, no flags).
REQ-016 DATA SHALL sample each bit one bit-time after the previous sample, LSB first, 7 or 8 bits per latched bit8.
REQ-017 After data: parity_en=1 -> PARITY, else STOP; PARITY samples one bit and compares with XOR of data bits (odd: XOR of data bits ^ parity bit = 1; even: = 0).
REQ-018 STOP SHALL sample one bit-time later; sampled 0 -> framing error; then IDLE (on 0, rearm only after line seen high).
REQ-019 The cycle after the stop sample, data/perr/ferr SHALL update and rxrdy SHALL assert; no other latency.
REQ-020 If rxrdy already 1 at completion and rd not asserted that cycle: data, perr and ferr SHALL keep the old byte, ovf SHALL set, and the new frame SHALL be dropped.
REQ-021 rd with rxrdy=1 SHALL clear rxrdy, perr, ferr, ovf next cycle; rd with rxrdy=0 SHALL have no effect.
REQ-022 rd coinciding with frame completion SHALL load the new frame, keep rxrdy=1, and leave ovf clear.
REQ-023 Bit-time counter SHALL be 19 bits, count down from the table value minus 1, reload on expiry; baud_val 12..15 SHALL use the entry for 11.

Reset
REQ-024 reset SHALL force IDLE, counters 0, synchronizer to 1, data=8'h00, rxrdy=perr=ferr=ovf=0 on the next edge.
REQ-025 reset mid-frame SHALL abandon the frame with no flags; the receiver rearms on the next falling edge after reset drops.

Configuration
REQ-026 Macro UART_RX_MAJORITY_VOTE_EN defined: each bit value is the majority of three synchronized samples at mid-bit -1, 0, +1 clocks; start validation uses the same vote.
REQ-027 Macro undefined: single sample at mid-bit; no vote logic compiled.

Structure
REQ-028 Package uart_pkg SHALL hold the 16-entry bit-time table (clocks per bit at CLK_HZ: 333333, 83333, 41667, 20833, 10417, 5208, 2604, 1736, 868, 434, 217, 109; 12..15 = 109), the state enum, and the counter width constant; TX and RX share it.
REQ-029 Sub-module uart_rx_bitclk SHALL hold the loadable bit-time down-counter and emit a one-cycle sample tick; FSM and flags stay in uart_rx_engine.

Verification (CLK_HZ=100 MHz, baud_val=11, 109 clocks/bit)
REQ-030 8-bit, odd parity, frame 0xA5 with parity bit 1 -> rxrdy=1 one cycle after stop sample, data=8'hA5, perr=0, ferr=0.
REQ-031 Same frame with parity bit 0 -> data=8'hA5, perr=1; rd pulse -> rxrdy and perr 0 next cycle.
REQ-032 7-bit, no parity, byte 0x55, stop bit driven 0 -> data=8'h55, ferr=1; rx then high; next frame 0x2A received cleanly.
REQ-033 Two 8-bit frames 0x11 then 0x22 with no rd -> data=8'h11, ovf=1; rd on completion cycle of a third frame 0x33 -> data=8'h33, rxrdy=1, ovf=0.
REQ-034 rx low for 30 clocks then high -> returns to IDLE, no flags; reset asserted at data bit 3 of a frame -> all outputs 0, next full frame 0x5A received correctly.
